// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state encoding and array types for the
// convolution input feeder.
//   IMG_W/K_W/N_IMG/DW  : image size, kernel size, images per burst, data width
//   PIX_PER_IMG, BURST_LEN, WIN_PER_IMG : derived burst/window counts
//   state_e             : feeder FSM states
package conv_pkg;
    localparam int IMG_W       = 6;
    localparam int K_W         = 3;
    localparam int N_IMG       = 2;
    localparam int DW          = 8;

    localparam int PIX_PER_IMG = IMG_W * IMG_W;          // 36
    localparam int BURST_LEN   = PIX_PER_IMG * N_IMG;    // 72
    localparam int WIN_SIDE    = IMG_W - K_W + 1;        // 4 windows per row
    localparam int WIN_PER_IMG = WIN_SIDE * WIN_SIDE;    // 16
    localparam int KER_N       = K_W * K_W;              // 9
    localparam int W_N         = 4;                      // 2x2 weights
    localparam int CNT_W       = $clog2(BURST_LEN);      // 7

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_e;

    typedef logic [BURST_LEN-1:0][DW-1:0] pix_buf_t;
    typedef logic [KER_N-1:0][DW-1:0]     win_t;
    typedef logic [W_N-1:0][DW-1:0]       wgt_t;
endpackage

// File: rtl/window_mux.sv
// window_mux: combinational 3x3 window selector.
//   pix : whole captured burst (both images)
//   img : image index of the window
//   pos : window position, row*4+col
//   win : 9 pixels, element (i,j) at index i*3+j
module window_mux
    import conv_pkg::*;
(
    input  pix_buf_t   pix,
    input  logic       img,
    input  logic [3:0] pos,
    output win_t       win
);
    // Top-left pixel of the window inside the flat burst buffer.
    logic [CNT_W-1:0] base;

    assign base = (img ? CNT_W'(PIX_PER_IMG) : '0)
                + CNT_W'(pos[3:2]) * CNT_W'(IMG_W)
                + CNT_W'(pos[1:0]);

    for (genvar i = 0; i < K_W; i++) begin : g_row
        for (genvar j = 0; j < K_W; j++) begin : g_col
            assign win[i*K_W+j] = pix[base + CNT_W'(i*IMG_W + j)];
        end
    end
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: captures a 72-sample burst (two 6x6 images, a 3x3
// kernel, 2x2 weights) and replays the 32 stride-1 3x3 windows over a
// valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/img/ker/weight : input burst
//   win_valid/win_ready : window handshake
//   win_data            : current 3x3 window
//   ker_data, w_data    : kernel and weights of the last completed burst
//   win_img, win_pos, win_last : window tags
//   busy, err           : activity flag, protocol-violation pulse
module conv_window_feeder
    import conv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   img,
    input  logic [DW-1:0]   ker,
    input  logic [DW-1:0]   weight,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [9*DW-1:0] win_data,
    output logic [9*DW-1:0] ker_data,
    output logic [4*DW-1:0] w_data,
    output logic            win_img,
    output logic [3:0]      win_pos,
    output logic            win_last,
    output logic            busy,
    output logic            err
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pix_buf_t         pix_q, pix_d;
    // Kernel/weights are staged and only published once the burst completes,
    // so an aborted burst never disturbs ker_data/w_data.
    win_t             ker_stage_q, ker_stage_d;
    wgt_t             w_stage_q, w_stage_d;
    win_t             ker_q, ker_d;
    wgt_t             w_q, w_d;
    logic             vld_q, vld_d;
    logic             img_q, img_d;
    logic [3:0]       pos_q, pos_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             last;
    win_t             win_sel;

    assign last = vld_q & img_q & (pos_q == 4'(WIN_PER_IMG-1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pix_d       = pix_q;
        ker_stage_d = ker_stage_q;
        w_stage_d   = w_stage_q;
        ker_d       = ker_q;
        w_d         = w_q;
        vld_d       = vld_q;
        img_d       = img_q;
        pos_d       = pos_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pix_d[0]       = img;
                    ker_stage_d[0] = ker;
                    w_stage_d[0]   = weight;
                    cnt_d          = CNT_W'(1);
                    busy_d         = 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    pix_d[cnt_q] = img;
                    if (cnt_q < CNT_W'(KER_N)) ker_stage_d[cnt_q[3:0]] = ker;
                    if (cnt_q < CNT_W'(W_N))   w_stage_d[cnt_q[1:0]]   = weight;
                    if (cnt_q == CNT_W'(BURST_LEN-1)) begin
                        cnt_d   = '0;
                        ker_d   = ker_stage_d;
                        w_d     = w_stage_d;
                        vld_d   = 1'b1;
                        img_d   = 1'b0;
                        pos_d   = '0;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Burst ended early: drop it without emitting anything.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            EMIT: begin
                err_d = in_valid;
                if (vld_q && win_ready) begin
                    if (last) begin
                        vld_d   = 1'b0;
                        busy_d  = 1'b0;
                        img_d   = 1'b0;
                        pos_d   = '0;
                        state_d = IDLE;
                    end else if (pos_q == 4'(WIN_PER_IMG-1)) begin
                        img_d = ~img_q;
                        pos_d = '0;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pix_q       <= '0;
            ker_stage_q <= '0;
            w_stage_q   <= '0;
            ker_q       <= '0;
            w_q         <= '0;
            vld_q       <= 1'b0;
            img_q       <= 1'b0;
            pos_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pix_q       <= pix_d;
            ker_stage_q <= ker_stage_d;
            w_stage_q   <= w_stage_d;
            ker_q       <= ker_d;
            w_q         <= w_d;
            vld_q       <= vld_d;
            img_q       <= img_d;
            pos_q       <= pos_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Window is selected from registered storage and registered tags, so it
    // has no path from the img input.
    window_mux u_mux (
        .pix (pix_q),
        .img (img_q),
        .pos (pos_q),
        .win (win_sel)
    );

    assign win_data  = win_sel;
    assign ker_data  = ker_q;
    assign w_data    = w_q;
    assign win_valid = vld_q;
    assign win_img   = img_q;
    assign win_pos   = pos_q;
    assign win_last  = last;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Input-staging stage placed directly upstream of the convolution/pooling/FC core. Captures the 72-cycle input burst (two 6x6 images, one 3x3 kernel, one 2x2 weight matrix) into local storage. Then replays the 32 stride-1 3x3 windows, 16 per image, to the core over a valid/ready handshake. The core no longer needs its own image buffer.

## Interface
Parameters:
- IMG_W, 6, image width and height
- K_W, 3, kernel width and height
- N_IMG, 2, images per burst
- DW, 8, data width of img/ker/weight

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  burst qualifier; high for exactly 72 consecutive cycles
- img  in  DW  image pixel, raster order, image 0 then image 1
- ker  in  DW  kernel element, valid on burst cycles 0-8, row-major
- weight  in  DW  weight element, valid on burst cycles 0-3, row-major
- win_valid  out  1  window available
- win_ready  in  1  core accepts window
- win_data  out  9*DW  3x3 window, element (r,c) at bits [(r*3+c)*DW +: DW]
- ker_data  out  9*DW  captured kernel, same packing
- w_data  out  4*DW  captured weights, element i at [i*DW +: DW]
- win_img  out  1  image index of current window
- win_pos  out  4  window position, row*4+col
- win_last  out  1  high with the final window (image 1, pos 15)
- busy  out  1  high in LOAD or EMIT
- err  out  1  one-cycle pulse on protocol violation

## Operation
- States: IDLE, LOAD, EMIT.
- IDLE:
  - in_valid=1 -> LOAD.
  - The sample on this cycle is sample 0 and is captured.
- LOAD:
  - Sample counter cnt 0..71 advances on each in_valid cycle.
  - img stored at buf[cnt].
  - ker stored when cnt<9.
  - weight stored when cnt<4.
  - ker and weight are ignored (X permitted) on all other cycles.
  - After cnt=71 is captured -> EMIT.
- Early drop: in_valid=0 in LOAD with cnt<72.
  - err pulses.
  - Partial data is discarded.
  - Return to IDLE.
  - No window is emitted.
- EMIT:
  - Windows are issued in order img 0 then 1, pos 0..15.
  - Window (img,r,c) is buf[img*36 + (r+i)*6 + (c+j)] for i,j in 0..2.
  - A transfer occurs when win_valid & win_ready.
  - After the transfer with win_last=1 -> IDLE.
- in_valid=1 during EMIT:
  - err pulses.
  - Input is ignored.
  - Emission continues undisturbed.
- ker_data and w_data hold the last completed burst's values from EMIT until the next burst's capture overwrites them.
- All data is unsigned and passed through unmodified; no arithmetic.

## Timing
- Reset values (all outputs, first cycle after rst sampled high):
  - win_valid=0, win_last=0, busy=0, err=0.
  - win_data, ker_data, w_data all 0.
  - win_img=0, win_pos=0.
  - State IDLE, counters 0.
- rst has priority over all activity. Reset mid-LOAD or mid-EMIT aborts with no err pulse.
- busy rises in the cycle after the first in_valid sample.
- win_valid rises the cycle after sample 71 is captured. Latency is 1 cycle.
- The first window is registered. win_data must not be a combinational path from img.
- While win_valid=1 and win_ready=0, all win_*/ker_data/w_data are held stable.
- After a transfer, the next window is valid the following cycle. Back-to-back with win_ready held high gives 32 windows in 32 cycles.
- win_valid never deasserts without a transfer, except on rst.
- After the last transfer:
  - win_valid=0 and busy=0 in the next cycle.
  - A new burst may start in that same cycle.
- err is a registered single-cycle pulse, one cycle after the offending sample.

## Structure
- Shared package conv_pkg holds:
  - IMG_W, K_W, N_IMG, DW.
  - Derived constants: PIX_PER_IMG=36, BURST_LEN=72, WIN_PER_IMG=16.
  - State enum {IDLE, LOAD, EMIT}.
- One sub-module, window_mux: purely combinational. It selects 9 pixels from the 72-entry buffer given (img,r,c).
- FSM, counters, storage and handshake live in the top module.

## Test plan
- Nominal burst:
  - Stimulus: img[k]=k for k 0..71, ker=1..9, weight=10..13, win_ready=1.
  - Window 0 = {0,1,2,6,7,8,12,13,14}.
  - Window pos 15 of img 1 = {57,58,59,63,64,65,69,70,71}.
  - ker_data=1..9, w_data=10..13.
  - win_last on the 32nd cycle.
- Backpressure:
  - Stimulus: win_ready toggles 1,0,0,1,...
  - Data stable during stalls.
  - Exactly 32 transfers, no duplicates or skips.
- Early drop:
  - Stimulus: in_valid drops after 40 samples.
  - err pulses once, state returns to IDLE, win_valid stays 0.
  - A following full burst emits correctly.
- Overlap violation:
  - Stimulus: in_valid asserted at window 5 of EMIT.
  - err pulses.
  - Remaining windows still match the first burst's data.
- Reset mid-EMIT:
  - Stimulus: rst at window 10.
  - Next cycle: all outputs at reset values, no err.
  - A new burst with img=255 for all samples gives all-255 windows.
- Back-to-back bursts:
  - Stimulus: second burst starts the cycle after the last transfer.
  - Captured correctly; its kernel replaces the first burst's kernel.
